// File: rtl/matvec_seq.sv
// Sequential matrix-vector multiply controller: streams ROWS matrix rows through an
// external dot-product datapath against one latched operand vector, one result per row.
module matvec_seq #(
    parameter int VEC_SIZE       = 16,
    parameter int ROWS           = 16,
    parameter int FIXPOINT_WIDTH = 16
) (
    input  logic                                  i_clk,
    input  logic                                  i_rst,
    input  logic                                  i_start,
    input  logic                                  i_abort,
    input  logic [VEC_SIZE*FIXPOINT_WIDTH-1:0]    i_vec,
    input  logic                                  i_row_valid,
    input  logic [VEC_SIZE*FIXPOINT_WIDTH-1:0]    i_row,
    output logic                                  o_row_ready,
    output logic [VEC_SIZE*FIXPOINT_WIDTH-1:0]    o_mul_a,
    output logic [VEC_SIZE*FIXPOINT_WIDTH-1:0]    o_mul_b,
    input  logic [FIXPOINT_WIDTH-1:0]             i_mul_dot,
    output logic                                  o_res_valid,
    output logic [FIXPOINT_WIDTH-1:0]             o_res,
    output logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0] o_res_idx,
    input  logic                                  i_res_ready,
    output logic                                  o_busy,
    output logic                                  o_done
);

    localparam int IDX_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int FW    = FIXPOINT_WIDTH;
    localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(ROWS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_CALC,
        S_OUT,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   cnt_q, cnt_d;
    logic [FW-1:0]      res_q, res_d;
    logic [IDX_W-1:0]   res_idx_q, res_idx_d;
    logic               row_ready_q, row_ready_d;
    logic               res_valid_q, res_valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               vec_latch;
    logic               row_latch;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        res_d     = res_q;
        res_idx_d = res_idx_q;
        vec_latch = 1'b0;
        row_latch = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    vec_latch = 1'b1;
                    cnt_d     = '0;
                    state_d   = S_FETCH;
                end
            end
            S_FETCH: begin
                if (i_row_valid) begin
                    row_latch = 1'b1;
                    state_d   = S_CALC;
                end
            end
            S_CALC: begin
                res_d     = i_mul_dot;
                res_idx_d = cnt_q;
                state_d   = S_OUT;
            end
            S_OUT: begin
                if (i_res_ready) begin
                    if (cnt_q == LAST_ROW) begin
                        state_d = S_DONE;
                    end else begin
                        cnt_d   = cnt_q + IDX_W'(1);
                        state_d = S_FETCH;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort wins over any handshake happening in the same cycle.
        if (i_abort && (state_q != S_IDLE)) begin
            state_d   = S_IDLE;
            cnt_d     = cnt_q;
            res_d     = res_q;
            res_idx_d = res_idx_q;
            row_latch = 1'b0;
        end

        // Status outputs are registered copies of the next state.
        row_ready_d = (state_d == S_FETCH);
        res_valid_d = (state_d == S_OUT);
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_DONE);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            res_q       <= '0;
            res_idx_q   <= '0;
            row_ready_q <= 1'b0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            res_q       <= res_d;
            res_idx_q   <= res_idx_d;
            row_ready_q <= row_ready_d;
            res_valid_q <= res_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Operand registers, one lane per vector element; they move only at the latch points.
    logic [VEC_SIZE*FW-1:0] mul_a_q, mul_a_d;
    logic [VEC_SIZE*FW-1:0] mul_b_q, mul_b_d;

    generate
        for (genvar gi = 0; gi < VEC_SIZE; gi++) begin : g_lane
            always_comb begin
                mul_a_d[gi*FW +: FW] = vec_latch ? i_vec[gi*FW +: FW] : mul_a_q[gi*FW +: FW];
                mul_b_d[gi*FW +: FW] = row_latch ? i_row[gi*FW +: FW] : mul_b_q[gi*FW +: FW];
            end

            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    mul_a_q[gi*FW +: FW] <= '0;
                    mul_b_q[gi*FW +: FW] <= '0;
                end else begin
                    mul_a_q[gi*FW +: FW] <= mul_a_d[gi*FW +: FW];
                    mul_b_q[gi*FW +: FW] <= mul_b_d[gi*FW +: FW];
                end
            end
        end
    endgenerate

    assign o_row_ready = row_ready_q;
    assign o_res_valid = res_valid_q;
    assign o_res       = res_q;
    assign o_res_idx   = res_idx_q;
    assign o_busy      = busy_q;
    assign o_done      = done_q;
    assign o_mul_a     = mul_a_q;
    assign o_mul_b     = mul_b_q;

endmodule
